// File: rtl/fwd_hazard_tracker.sv
// fwd_hazard_tracker
//
// Forwarding and load-use hazard unit for the rv32i pipeline. It sits beside
// the EX stage and keeps a shadow copy of the in-flight writers in the
// downstream stages (stage 1 = MEM, stage 2 = WB, ...). Each writer entry
// holds {valid, wr, is_load, dest}.
//
// For every EX source operand it reports the youngest downstream stage that
// will write that register. It raises stall when that youngest producer is
// a load whose data is not yet available. Freeze and flush are applied to
// the shadow pipeline so that it tracks the real one.
//
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   ex_valid      EX holds a real instruction
//   ex_src        NUM_SRC packed source indices, src s at [s*REG_AW +: REG_AW]
//   ex_src_used   per-source "operand actually read" flags
//   ex_dest       EX destination register
//   ex_wr         EX instruction writes the register file
//   ex_is_load    EX instruction is a load
//   pipe_advance  pipeline moves this cycle (0 = memory freeze)
//   flush         kill the EX instruction (redirect)
//   stat_clr      synchronous clear of stall_count
//   fwd_sel       per-source select: 0 = regfile, k = stage k result
//   stall         load-use hazard, hold IF/ID/EX
//   bubble        a bubble enters stage 1 on this edge
//   stall_count   saturating count of advancing stall cycles
module fwd_hazard_tracker #(
    parameter int NUM_SRC          = 2,
    parameter int NUM_STAGES       = 2,
    parameter int LOAD_READY_STAGE = 2,
    parameter int REG_AW           = 5,
    parameter int SELW             = $clog2(NUM_STAGES + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ex_valid,
    input  logic [NUM_SRC*REG_AW-1:0] ex_src,
    input  logic [NUM_SRC-1:0]        ex_src_used,
    input  logic [REG_AW-1:0]         ex_dest,
    input  logic                      ex_wr,
    input  logic                      ex_is_load,
    input  logic                      pipe_advance,
    input  logic                      flush,
    input  logic                      stat_clr,
    output logic [NUM_SRC*SELW-1:0]   fwd_sel,
    output logic                      stall,
    output logic                      bubble,
    output logic [31:0]               stall_count
);

    // Shadow writer pipeline, index 1 is the youngest (MEM) stage.
    logic [NUM_STAGES:1] valid_q, valid_d;
    logic [NUM_STAGES:1] wr_q,    wr_d;
    logic [NUM_STAGES:1] ld_q,    ld_d;
    logic [REG_AW-1:0]   dest_q [1:NUM_STAGES];
    logic [REG_AW-1:0]   dest_d [1:NUM_STAGES];

    logic [31:0]              stall_count_q, stall_count_d;
    logic [NUM_SRC*SELW-1:0]  fwd_sel_s;
    logic [NUM_SRC-1:0]       haz_s;
    logic                     stall_s;
    logic                     bubble_s;

    // Forward select and hazard detection per source operand.
    always_comb begin
        fwd_sel_s = '0;
        haz_s     = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            // Walk from oldest to youngest so the youngest match is the
            // last one written and therefore wins.
            for (int k = NUM_STAGES; k >= 1; k--) begin
                if (ex_src_used[s] && (ex_src[s*REG_AW +: REG_AW] != '0) &&
                    valid_q[k] && wr_q[k] &&
                    (dest_q[k] == ex_src[s*REG_AW +: REG_AW])) begin
                    fwd_sel_s[s*SELW +: SELW] = SELW'(k);
                    haz_s[s]                  = ld_q[k] && (k < LOAD_READY_STAGE);
                end else begin
                    haz_s[s] = haz_s[s];
                end
            end
        end
    end

    // Stall and bubble generation; flush suppresses the stall.
    always_comb begin
        stall_s  = ex_valid && !flush && (|haz_s);
        bubble_s = pipe_advance && (stall_s || flush || !ex_valid);
    end

    // Next state of the shadow pipeline: shift on advance, hold on freeze.
    always_comb begin
        valid_d = valid_q;
        wr_d    = wr_q;
        ld_d    = ld_q;
        dest_d  = dest_q;
        if (pipe_advance) begin
            for (int k = NUM_STAGES; k >= 2; k--) begin
                valid_d[k] = valid_q[k-1];
                wr_d[k]    = wr_q[k-1];
                ld_d[k]    = ld_q[k-1];
                dest_d[k]  = dest_q[k-1];
            end
            if (ex_valid && !stall_s && !flush) begin
                valid_d[1] = 1'b1;
                wr_d[1]    = ex_wr;
                ld_d[1]    = ex_is_load;
                dest_d[1]  = ex_dest;
            end else begin
                valid_d[1] = 1'b0;
                wr_d[1]    = 1'b0;
                ld_d[1]    = 1'b0;
                dest_d[1]  = '0;
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // Saturating stall counter; clear takes priority over increment.
    always_comb begin
        stall_count_d = stall_count_q;
        if (stat_clr) begin
            stall_count_d = 32'd0;
        end else if (stall_s && pipe_advance && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end else begin
            stall_count_d = stall_count_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q       <= '0;
            wr_q          <= '0;
            ld_q          <= '0;
            for (int k = 1; k <= NUM_STAGES; k++) begin
                dest_q[k] <= '0;
            end
            stall_count_q <= 32'd0;
        end else begin
            valid_q       <= valid_d;
            wr_q          <= wr_d;
            ld_q          <= ld_d;
            for (int k = 1; k <= NUM_STAGES; k++) begin
                dest_q[k] <= dest_d[k];
            end
            stall_count_q <= stall_count_d;
        end
    end

    assign fwd_sel     = fwd_sel_s;
    assign stall       = stall_s;
    assign bubble      = bubble_s;
    assign stall_count = stall_count_q;

endmodule
